// File: rtl/hwpf_stride_sched.sv
// hwpf_stride_sched: round-robin arbiter that shares one dcache request port among stride-prefetch engines.
// Request/response paths are combinational; `HWPF_STRIDE_SCHED_OUTREG_EN adds a 1-cycle registered request stage.
package hwpf_stride_sched_pkg;
  typedef logic [2:0] hpdcache_req_sid_t;
  typedef logic [3:0] hpdcache_req_tid_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic [3:0]        op;
    logic [2:0]        size;
    logic              need_rsp;
    hpdcache_req_sid_t sid;
    hpdcache_req_tid_t tid;
  } hpdcache_req_t;

  typedef struct packed {
    logic [31:0]       rdata;
    hpdcache_req_sid_t sid;
    hpdcache_req_tid_t tid;
    logic              error;
  } hpdcache_rsp_t;
endpackage

module hwpf_stride_sched
  import hwpf_stride_sched_pkg::*;
#(
  parameter int unsigned NUM_HW_PREFETCH = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic          [NUM_HW_PREFETCH-1:0]  eng_req_valid_i,
  output logic          [NUM_HW_PREFETCH-1:0]  eng_req_ready_o,
  input  hpdcache_req_t [NUM_HW_PREFETCH-1:0]  eng_req_i,
  output logic          [NUM_HW_PREFETCH-1:0]  eng_rsp_valid_o,
  output hpdcache_rsp_t [NUM_HW_PREFETCH-1:0]  eng_rsp_o,
  input  hpdcache_req_sid_t                    dcache_req_sid_i,
  output logic                                 dcache_req_valid_o,
  input  logic                                 dcache_req_ready_i,
  output hpdcache_req_t                        dcache_req_o,
  input  logic                                 dcache_rsp_valid_i,
  input  hpdcache_rsp_t                        dcache_rsp_i,
  output logic                                 err_o
);
  localparam int unsigned GW = (NUM_HW_PREFETCH > 1) ? $clog2(NUM_HW_PREFETCH) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  typedef logic [GW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  cnt_t [NUM_HW_PREFETCH-1:0] cnt_q, cnt_d;
  idx_t                       ptr_q, ptr_d;
  logic                       err_q, err_d;
  logic [NUM_HW_PREFETCH-1:0] elig;
  logic                       any_elig;
  idx_t                       winner, cand;
  logic                       issue;
  idx_t                       sel_idx;
  hpdcache_req_t              req_fmt;
  logic                       lock_drop;
  idx_t                       rsp_idx;
  logic                       rsp_in_range, rsp_match;
  logic [NUM_HW_PREFETCH-1:0] inc_v, dec_v;

  // Scan from ptr downwards in reverse so the candidate nearest ptr is written last and wins.
  always_comb begin
    any_elig = 1'b0;
    winner   = '0;
    cand     = '0;
    for (int i = 0; i < int'(NUM_HW_PREFETCH); i++) begin
      elig[i] = eng_req_valid_i[i] &&
                ((cnt_q[i] < cnt_t'(MAX_OUTSTANDING)) || !eng_req_i[i].need_rsp);
    end
    for (int k = int'(NUM_HW_PREFETCH) - 1; k >= 0; k--) begin
      cand = idx_t'((int'(ptr_q) + k) % int'(NUM_HW_PREFETCH));
      if (elig[cand]) begin
        any_elig = 1'b1;
        winner   = cand;
      end
    end
  end

  always_comb begin
    req_fmt     = eng_req_i[sel_idx];
    req_fmt.sid = dcache_req_sid_i;
    req_fmt.tid = hpdcache_req_tid_t'(sel_idx);
  end

`ifdef HWPF_STRIDE_SCHED_OUTREG_EN
  logic          out_vld_q;
  hpdcache_req_t out_q;
  logic          load_en;

  // The register loads whenever it is empty or being drained, so throughput stays at one per cycle.
  assign load_en            = !out_vld_q || dcache_req_ready_i;
  assign issue              = any_elig && load_en && !rst_i;
  assign sel_idx            = winner;
  assign lock_drop          = 1'b0;
  assign dcache_req_valid_o = out_vld_q;
  assign dcache_req_o       = out_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (load_en) begin
      out_vld_q <= issue;
      if (issue) out_q <= req_fmt;
    end
  end
`else
  typedef enum logic {S_IDLE, S_LOCK} state_e;
  state_e state_q, state_d;
  idx_t   gnt_q, gnt_d;

  always_comb begin
    state_d            = state_q;
    gnt_d              = gnt_q;
    sel_idx            = winner;
    dcache_req_valid_o = 1'b0;
    lock_drop          = 1'b0;
    case (state_q)
      S_IDLE: begin
        dcache_req_valid_o = any_elig;
        if (any_elig && !dcache_req_ready_i) begin
          state_d = S_LOCK;
          gnt_d   = winner;
        end
      end
      S_LOCK: begin
        sel_idx            = gnt_q;
        dcache_req_valid_o = 1'b1;
        lock_drop          = !eng_req_valid_i[gnt_q];
        if (dcache_req_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst_i) begin
      dcache_req_valid_o = 1'b0;
      lock_drop          = 1'b0;
    end
  end

  assign issue        = dcache_req_valid_o && dcache_req_ready_i;
  assign dcache_req_o = req_fmt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end
`endif

  assign rsp_idx      = idx_t'(dcache_rsp_i.tid);
  assign rsp_in_range = (32'(dcache_rsp_i.tid) < NUM_HW_PREFETCH);
  assign rsp_match    = dcache_rsp_valid_i && !rst_i && rsp_in_range && (cnt_q[rsp_idx] != '0);

  always_comb begin
    for (int i = 0; i < int'(NUM_HW_PREFETCH); i++) begin
      eng_req_ready_o[i] = issue && (sel_idx == idx_t'(i));
      eng_rsp_valid_o[i] = rsp_match && (rsp_idx == idx_t'(i));
      eng_rsp_o[i]       = dcache_rsp_i;
      inc_v[i]           = issue && (sel_idx == idx_t'(i)) && eng_req_i[i].need_rsp;
      dec_v[i]           = eng_rsp_valid_o[i];
      cnt_d[i]           = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) cnt_d[i] = cnt_q[i] + cnt_t'(1);
      else if (dec_v[i] && !inc_v[i]) cnt_d[i] = cnt_q[i] - cnt_t'(1);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (sel_idx == idx_t'(NUM_HW_PREFETCH - 1)) ? '0 : sel_idx + idx_t'(1);
    err_d = err_q || (dcache_rsp_valid_i && !rsp_match) || lock_drop;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
endmodule

// File: tb/tb_hwpf_stride_sched.sv
// Bench for hwpf_stride_sched in its default (combinational) build, 4 engines, 2 outstanding.
module tb_hwpf_stride_sched;
  import hwpf_stride_sched_pkg::*;

  localparam int N = 4;
  localparam hpdcache_req_sid_t SID = 3'd5;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] nrsp;
    logic       rdy;
    logic       rvld;
    logic [3:0] rtid;
    logic       evld;
    logic [3:0] etid;
    logic [3:0] erdy;
    logic [3:0] ersp;
    logic       eerr;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic          [N-1:0]   eng_req_valid;
  logic          [N-1:0]   eng_req_ready;
  hpdcache_req_t [N-1:0]   eng_req;
  logic          [N-1:0]   eng_rsp_valid;
  hpdcache_rsp_t [N-1:0]   eng_rsp;
  logic                    dreq_valid;
  logic                    dreq_ready;
  hpdcache_req_t           dreq;
  logic                    drsp_valid;
  hpdcache_rsp_t           drsp;
  logic                    err;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  hwpf_stride_sched #(.NUM_HW_PREFETCH(N), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .eng_req_valid_i(eng_req_valid), .eng_req_ready_o(eng_req_ready), .eng_req_i(eng_req),
    .eng_rsp_valid_o(eng_rsp_valid), .eng_rsp_o(eng_rsp),
    .dcache_req_sid_i(SID),
    .dcache_req_valid_o(dreq_valid), .dcache_req_ready_i(dreq_ready), .dcache_req_o(dreq),
    .dcache_rsp_valid_i(drsp_valid), .dcache_rsp_i(drsp),
    .err_o(err)
  );

  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] nr, logic rd, logic rv,
                              logic [3:0] rt, logic ev, logic [3:0] et, logic [3:0] er,
                              logic [3:0] es, logic ee);
    vec_t x;
    x.rst = r; x.vld = v; x.nrsp = nr; x.rdy = rd; x.rvld = rv; x.rtid = rt;
    x.evld = ev; x.etid = et; x.erdy = er; x.ersp = es; x.eerr = ee;
    return x;
  endfunction

  function automatic hpdcache_req_t base_req(int i, logic nr);
    hpdcache_req_t r;
    r.addr     = 32'h4000_0000 + 32'(i) * 32'h100;
    r.op       = 4'(i);
    r.size     = 3'd3;
    r.need_rsp = nr;
    r.sid      = 3'd0;
    r.tid      = 4'hE;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (check %0d)", name, act, req, checks);
    end
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    hpdcache_req_t xr;
    hpdcache_rsp_t rs;
    @(posedge clk);
    #1;
    rst           = v.rst;
    eng_req_valid = v.vld;
    for (int i = 0; i < N; i++) eng_req[i] = base_req(i, v.nrsp[i]);
    dreq_ready    = v.rdy;
    drsp_valid    = v.rvld;
    drsp          = '{rdata: 32'hABCD_0000 + 32'(checks), sid: SID, tid: v.rtid, error: 1'b0};
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      chk("dcache_req_valid", 64'(dreq_valid), 64'(e.evld));
      chk("eng_req_ready", 64'(eng_req_ready), 64'(e.erdy));
      chk("eng_rsp_valid", 64'(eng_rsp_valid), 64'(e.ersp));
      chk("err", 64'(err), 64'(e.eerr));
      if (e.evld) begin
        xr     = base_req(int'(e.etid), e.nrsp[e.etid[1:0]]);
        xr.sid = SID;
        xr.tid = e.etid;
        chk("dcache_req", 64'(dreq), 64'(xr));
      end
      if (e.rvld) begin
        rs = drsp;
        chk("eng_rsp_bcast", 64'(eng_rsp[3]), 64'(rs));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; eng_req_valid = '0; dreq_ready = 1'b0; drsp_valid = 1'b0; drsp = '0;
    for (int i = 0; i < N; i++) eng_req[i] = base_req(i, 1'b0);

    // Reset: outputs gated, stray response during reset is not flagged afterwards.
    tbl.push_back(mk(1, 4'hF, 4'h0, 1, 1, 4'd0,  0, 4'd0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'd0,  0, 4'd0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 0, 4'd0,  0, 4'd0, 4'h0, 4'h0, 0));
    // Round robin, all engines valid.
    tbl.push_back(mk(0, 4'hF, 4'h0, 1, 0, 4'd0,  1, 4'd0, 4'h1, 4'h0, 0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 1, 0, 4'd0,  1, 4'd1, 4'h2, 4'h0, 0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 1, 0, 4'd0,  1, 4'd2, 4'h4, 4'h0, 0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 1, 0, 4'd0,  1, 4'd3, 4'h8, 4'h0, 0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 1, 0, 4'd0,  1, 4'd0, 4'h1, 4'h0, 0));
    // Lock on engine 2 while engine 0 joins; engine 0 follows.
    tbl.push_back(mk(0, 4'h4, 4'h0, 0, 0, 4'd0,  1, 4'd2, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h5, 4'h0, 0, 0, 4'd0,  1, 4'd2, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h5, 4'h0, 0, 0, 4'd0,  1, 4'd2, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h5, 4'h0, 1, 0, 4'd0,  1, 4'd2, 4'h4, 4'h0, 0));
    tbl.push_back(mk(0, 4'h1, 4'h0, 1, 0, 4'd0,  1, 4'd0, 4'h1, 4'h0, 0));
    // Outstanding cap on engine 1.
    tbl.push_back(mk(0, 4'h2, 4'h2, 1, 0, 4'd0,  1, 4'd1, 4'h2, 4'h0, 0));
    tbl.push_back(mk(0, 4'h2, 4'h2, 1, 0, 4'd0,  1, 4'd1, 4'h2, 4'h0, 0));
    tbl.push_back(mk(0, 4'h2, 4'h2, 1, 0, 4'd0,  0, 4'd0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h2, 4'h2, 1, 1, 4'd1,  0, 4'd0, 4'h0, 4'h2, 0));
    tbl.push_back(mk(0, 4'h2, 4'h2, 1, 0, 4'd0,  1, 4'd1, 4'h2, 4'h0, 0));
    // Coincident accept and response on engine 1 at cnt=1 keeps cnt at 1.
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 1, 4'd1,  0, 4'd0, 4'h0, 4'h2, 0));
    tbl.push_back(mk(0, 4'h2, 4'h2, 1, 1, 4'd1,  1, 4'd1, 4'h2, 4'h2, 0));
    tbl.push_back(mk(0, 4'h2, 4'h2, 1, 0, 4'd0,  1, 4'd1, 4'h2, 4'h0, 0));
    tbl.push_back(mk(0, 4'h2, 4'h2, 1, 0, 4'd0,  0, 4'd0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 1, 4'd1,  0, 4'd0, 4'h0, 4'h2, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 1, 4'd1,  0, 4'd0, 4'h0, 4'h2, 0));
    // Out-of-range tid, then unmatched tid with cnt=0; err is sticky.
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 1, 4'd7,  0, 4'd0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'h0, 1, 1, 4'd1,  0, 4'd0, 4'h0, 4'h0, 1));
    tbl.push_back(mk(0, 4'h8, 4'h8, 1, 0, 4'd0,  1, 4'd3, 4'h8, 4'h0, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset mid-LOCK abandons the grant and clears counters.
    apply(mk(0, 4'h1, 4'h1, 0, 0, 4'd0,  1, 4'd0, 4'h0, 4'h0, 1));
    apply(mk(1, 4'h1, 4'h1, 0, 0, 4'd0,  0, 4'd0, 4'h0, 4'h0, 1));
    apply(mk(0, 4'h0, 4'h0, 0, 0, 4'd0,  0, 4'd0, 4'h0, 4'h0, 0));
    // Granted engine drops valid while locked.
    apply(mk(0, 4'h2, 4'h0, 0, 0, 4'd0,  1, 4'd1, 4'h0, 4'h0, 0));
    apply(mk(0, 4'h0, 4'h0, 0, 0, 4'd0,  1, 4'd1, 4'h0, 4'h0, 0));
    apply(mk(0, 4'h2, 4'h0, 1, 0, 4'd0,  1, 4'd1, 4'h2, 4'h0, 1));
    apply(mk(1, 4'h0, 4'h0, 0, 0, 4'd0,  0, 4'd0, 4'h0, 4'h0, 1));
    // Engine 3 had one request in flight before reset; its late response is now unmatched.
    apply(mk(0, 4'h0, 4'h0, 1, 1, 4'd3,  0, 4'd0, 4'h0, 4'h0, 0));
    apply(mk(0, 4'h0, 4'h0, 1, 0, 4'd0,  0, 4'd0, 4'h0, 4'h0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
